// File: rtl/rank_filter_kxk.sv
// rank_filter_kxk: K x K sliding-window rank-order filter.
// Columns arrive one per valid cycle. Each completed window launches a token
// into a radix-select pipeline that resolves one result bit per stage, MSB
// first, and returns the pixel at the requested rank of the sorted window.
module rank_filter_kxk #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  localparam int N      = K * K,
  localparam int RANK_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  sol_i,
  input  logic [K*DATA_W-1:0]   col_i,
  input  logic [RANK_W-1:0]     rank_i,
  output logic [DATA_W-1:0]     pixel_o,
  output logic                  valid_o
);

  localparam int CNT_W  = $clog2(N + 1);
  localparam int FILL_W = $clog2(K + 1);

  // Per-element classification relative to the prefix resolved so far.
  localparam logic [1:0] TAG_LESS = 2'd0;
  localparam logic [1:0] TAG_EQ   = 2'd1;
  localparam logic [1:0] TAG_GT   = 2'd2;

  // Window: column 0 is the newest, column K-1 the oldest.
  logic [K-1:0][K*DATA_W-1:0] r_win;
  logic [FILL_W-1:0]          r_fill;
  logic [FILL_W-1:0]          w_fill_nx;
  logic                       w_launch;
  logic [CNT_W-1:0]           w_rank_c;
  logic                       r_vld0;
  logic [CNT_W-1:0]           r_rank0;

  // Stage inputs; index 0 is fed from the window, index s+1 from stage s.
  logic [N-1:0][DATA_W-1:0] w_pix  [DATA_W];
  logic [N-1:0][1:0]        w_tag  [DATA_W];
  logic [CNT_W-1:0]         w_less [DATA_W];
  logic [CNT_W-1:0]         w_rank [DATA_W];
  logic [DATA_W-1:0]        w_res  [DATA_W];
  logic                     w_vld  [DATA_W];

  // Fill tracking, launch detection and rank clamping.
  always_comb begin
    w_fill_nx = r_fill;
    if (valid_i) begin
      if (sol_i) begin
        w_fill_nx = FILL_W'(1);
      end else if (r_fill != FILL_W'(K)) begin
        w_fill_nx = r_fill + FILL_W'(1);
      end else begin
        w_fill_nx = r_fill;
      end
    end else begin
      w_fill_nx = r_fill;
    end
    w_launch = valid_i && (w_fill_nx == FILL_W'(K));
    if (CNT_W'(rank_i) > CNT_W'(N - 1)) begin
      w_rank_c = CNT_W'(N - 1);
    end else begin
      w_rank_c = CNT_W'(rank_i);
    end
  end

  // Window shift, fill counter and launch token registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win   <= '0;
      r_fill  <= FILL_W'(0);
      r_vld0  <= 1'b0;
      r_rank0 <= CNT_W'(0);
    end else begin
      r_fill <= w_fill_nx;
      r_vld0 <= w_launch;
      if (w_launch) begin
        r_rank0 <= w_rank_c;
      end else begin
        r_rank0 <= r_rank0;
      end
      if (valid_i) begin
        r_win[0] <= col_i;
        for (int c = 1; c < K; c++) begin
          r_win[c] <= r_win[c-1];
        end
      end else begin
        r_win <= r_win;
      end
    end
  end

  // The window register is the token payload for the first bit stage.
  assign w_pix[0]  = r_win;
  assign w_tag[0]  = {N{TAG_EQ}};
  assign w_less[0] = CNT_W'(0);
  assign w_rank[0] = r_rank0;
  assign w_res[0]  = DATA_W'(0);
  assign w_vld[0]  = r_vld0;

  for (genvar s = 0; s < DATA_W; s++) begin : g_stage
    localparam int B = DATA_W - 1 - s;
    logic [CNT_W-1:0]  w_z;
    logic              w_bit;
    logic [DATA_W-1:0] w_res_nx;

    // Count still-tied elements with a 0 at bit B and decide result bit B.
    always_comb begin
      w_z = CNT_W'(0);
      for (int e = 0; e < N; e++) begin
        w_z = w_z + CNT_W'((w_tag[s][e] == TAG_EQ) && !w_pix[s][e][B]);
      end
      w_bit       = (w_rank[s] >= (w_less[s] + w_z));
      w_res_nx    = w_res[s];
      w_res_nx[B] = w_bit;
    end

    if (s < DATA_W - 1) begin : g_mid
      logic [N-1:0][1:0]        w_tag_nx;
      logic [CNT_W-1:0]         w_less_nx;
      logic                     r_vld;
      logic [N-1:0][DATA_W-1:0] r_pix;
      logic [N-1:0][1:0]        r_tag;
      logic [CNT_W-1:0]         r_less;
      logic [CNT_W-1:0]         r_rank;
      logic [DATA_W-1:0]        r_res;

      // Split tied elements that disagree with the chosen bit into LESS/GREATER.
      always_comb begin
        w_tag_nx = w_tag[s];
        for (int e = 0; e < N; e++) begin
          if ((w_tag[s][e] == TAG_EQ) && (w_pix[s][e][B] != w_bit)) begin
            w_tag_nx[e] = w_bit ? TAG_LESS : TAG_GT;
          end else begin
            w_tag_nx[e] = w_tag[s][e];
          end
        end
        if (w_bit) begin
          w_less_nx = w_less[s] + w_z;
        end else begin
          w_less_nx = w_less[s];
        end
      end

      // Stage register; advances every cycle, bubbles carry valid = 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld  <= 1'b0;
          r_pix  <= '0;
          r_tag  <= '0;
          r_less <= CNT_W'(0);
          r_rank <= CNT_W'(0);
          r_res  <= DATA_W'(0);
        end else begin
          r_vld  <= w_vld[s];
          r_pix  <= w_pix[s];
          r_tag  <= w_tag_nx;
          r_less <= w_less_nx;
          r_rank <= w_rank[s];
          r_res  <= w_res_nx;
        end
      end

      assign w_vld[s+1]  = r_vld;
      assign w_pix[s+1]  = r_pix;
      assign w_tag[s+1]  = r_tag;
      assign w_less[s+1] = r_less;
      assign w_rank[s+1] = r_rank;
      assign w_res[s+1]  = r_res;
    end else begin : g_last
      // Output register; pixel_o keeps its last result between valid cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_o <= 1'b0;
          pixel_o <= DATA_W'(0);
        end else begin
          valid_o <= w_vld[s];
          if (w_vld[s]) begin
            pixel_o <= w_res_nx;
          end else begin
            pixel_o <= pixel_o;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rank_filter_kxk.sv
// Scoreboard bench for rank_filter_kxk: a K=3 and a K=5 instance, directed
// column streams, expected results queued with their due cycle and checked
// by an independent monitor on the falling clock edge.
module tb_rank_filter_kxk;

  typedef struct {
    int         t;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic        v3, s3, vo3;
  logic [23:0] c3;
  logic [3:0]  r3;
  logic [7:0]  p3;

  logic        v5, s5, vo5;
  logic [39:0] c5;
  logic [4:0]  r5;
  logic [7:0]  p5;

  exp_t q3[$];
  exp_t q5[$];

  logic [23:0] sc [10];

  always #5 clk = ~clk;

  // Cycle counter used to pin down result latency.
  always @(posedge clk) cyc <= cyc + 1;

  rank_filter_kxk #(.K(3), .DATA_W(8)) u_k3 (
    .clk(clk), .rst(rst), .valid_i(v3), .sol_i(s3), .col_i(c3),
    .rank_i(r3), .pixel_o(p3), .valid_o(vo3)
  );

  rank_filter_kxk #(.K(5), .DATA_W(8)) u_k5 (
    .clk(clk), .rst(rst), .valid_i(v5), .sol_i(s5), .col_i(c5),
    .rank_i(r5), .pixel_o(p5), .valid_o(vo5)
  );

  // Monitor: pop and compare whenever a DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (vo3) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL k3_unexpected: valid_o with pixel_o=%0d at cycle %0d, none expected", p3, cyc);
      end else begin
        e = q3.pop_front();
        if (p3 !== e.v || cyc != e.t) begin
          fails++;
          $display("FAIL k3_result: pixel_o=%0d at cycle %0d, want %0d at cycle %0d", p3, cyc, e.v, e.t);
        end
      end
    end
    if (vo5) begin
      tests++;
      if (q5.size() == 0) begin
        fails++;
        $display("FAIL k5_unexpected: valid_o with pixel_o=%0d at cycle %0d, none expected", p5, cyc);
      end else begin
        e = q5.pop_front();
        if (p5 !== e.v || cyc != e.t) begin
          fails++;
          $display("FAIL k5_result: pixel_o=%0d at cycle %0d, want %0d at cycle %0d", p5, cyc, e.v, e.t);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Present one valid column to the K=3 instance; optionally queue its result.
  task automatic drive3(input logic [23:0] col, input logic sol, input logic [3:0] rank,
                        input bit has_exp, input logic [7:0] expv);
    @(posedge clk);
    #1;
    v3 = 1'b1; s3 = sol; c3 = col; r3 = rank;
    if (has_exp) q3.push_back('{t: cyc + 9, v: expv});
  endtask

  task automatic idle3(input logic sol_noise);
    @(posedge clk);
    #1;
    v3 = 1'b0; s3 = sol_noise;
  endtask

  task automatic drive5(input logic [39:0] col, input logic sol, input logic [4:0] rank,
                        input bit has_exp, input logic [7:0] expv);
    @(posedge clk);
    #1;
    v5 = 1'b1; s5 = sol; c5 = col; r5 = rank;
    if (has_exp) q5.push_back('{t: cyc + 9, v: expv});
  endtask

  task automatic idle5();
    @(posedge clk);
    #1;
    v5 = 1'b0; s5 = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) idle3(1'b0);
  endtask

  // Reference: full sort of the 3x3 window, then pick the clamped rank.
  function automatic logic [7:0] sel3(input logic [23:0] a, input logic [23:0] b,
                                      input logic [23:0] c, input logic [3:0] rank);
    logic [7:0] v [9];
    logic [7:0] t;
    int r;
    for (int i = 0; i < 3; i++) begin
      v[i]   = a[8*i +: 8];
      v[3+i] = b[8*i +: 8];
      v[6+i] = c[8*i +: 8];
    end
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    r = (rank > 4'd8) ? 8 : int'(rank);
    return v[r];
  endfunction

  task automatic run_stream(input bit gapped);
    logic [7:0] ev;
    logic [3:0] rk;
    bit has;
    int gap;
    for (int i = 0; i < 10; i++) begin
      rk  = 4'((i * 5) % 16);
      has = (i % 5) >= 2;
      if (has) ev = sel3(sc[i-2], sc[i-1], sc[i], rk);
      else     ev = 8'd0;
      drive3(sc[i], (i == 0 || i == 5), rk, has, ev);
      if (gapped) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) idle3(1'($urandom_range(0, 1)));
      end
    end
    idle3(1'b0);
  endtask

  initial begin
    logic [23:0] ca, cb, cc;
    logic [39:0] a7, lo, hi;
    logic [3:0]  rks [5];
    logic [7:0]  exs [5];
    logic [4:0]  rk5 [3];
    logic [7:0]  ex5 [3];

    rst = 1'b1;
    v3 = 1'b0; s3 = 1'b0; c3 = 24'd0; r3 = 4'd0;
    v5 = 1'b0; s5 = 1'b0; c5 = 40'd0; r5 = 5'd0;
    sc = '{24'h102030, 24'h0A0A0A, 24'hFF0001, 24'h7F807E, 24'h050505,
           24'h332211, 24'hC0C0C0, 24'h00FF00, 24'h123456, 24'h808080};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_k3_pixel", int'(p3), 0);
    check("reset_k3_valid", int'(vo3), 0);
    check("reset_k5_pixel", int'(p5), 0);
    check("reset_k5_valid", int'(vo5), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Ramp window {1..9} queried at several ranks, one line per rank.
    ca = {8'd3, 8'd2, 8'd1};
    cb = {8'd6, 8'd5, 8'd4};
    cc = {8'd9, 8'd8, 8'd7};
    rks = '{4'd4, 4'd0, 4'd8, 4'd15, 4'd2};
    exs = '{8'd5, 8'd1, 8'd9, 8'd9, 8'd3};
    for (int k = 0; k < 5; k++) begin
      drive3(ca, 1'b1, rks[k], 1'b0, 8'd0);
      drive3(cb, 1'b0, rks[k], 1'b0, 8'd0);
      drive3(cc, 1'b0, rks[k], 1'b1, exs[k]);
    end
    wait_cycles(14);
    @(negedge clk);
    check("hold_k3_pixel", int'(p3), 3);
    check("hold_k3_valid", int'(vo3), 0);

    // K=5 window of 0xA7 with a single 0x00 and a single 0xFF.
    a7 = {5{8'hA7}};
    lo = {8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'h00};
    hi = {8'hFF, 8'hA7, 8'hA7, 8'hA7, 8'hA7};
    rk5 = '{5'd0, 5'd12, 5'd24};
    ex5 = '{8'h00, 8'hA7, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      drive5(lo, 1'b1, rk5[k], 1'b0, 8'd0);
      drive5(a7, 1'b0, rk5[k], 1'b0, 8'd0);
      drive5(a7, 1'b0, rk5[k], 1'b0, 8'd0);
      drive5(a7, 1'b0, rk5[k], 1'b0, 8'd0);
      drive5(hi, 1'b0, rk5[k], 1'b1, ex5[k]);
    end
    idle5();
    repeat (14) idle5();
    @(negedge clk);
    check("hold_k5_pixel", int'(p5), 255);

    // Two lines in one back-to-back stream, then the same with idle gaps.
    run_stream(1'b0);
    wait_cycles(12);
    run_stream(1'b1);
    wait_cycles(12);

    // Reset shortly after a launch: the token must vanish.
    drive3(ca, 1'b1, 4'd4, 1'b0, 8'd0);
    drive3(cb, 1'b0, 4'd4, 1'b0, 8'd0);
    drive3(cc, 1'b0, 4'd4, 1'b0, 8'd0);
    idle3(1'b0);
    idle3(1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_k3_pixel", int'(p3), 0);
    check("midrst_k3_valid", int'(vo3), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // No sol_i: the fill counter must start from zero after reset.
    drive3(sc[3], 1'b0, 4'd4, 1'b0, 8'd0);
    drive3(sc[4], 1'b0, 4'd4, 1'b0, 8'd0);
    drive3(sc[5], 1'b0, 4'd4, 1'b1, sel3(sc[3], sc[4], sc[5], 4'd4));
    wait_cycles(16);

    check("k3_queue_drained", q3.size(), 0);
    check("k5_queue_drained", q5.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
